t07_fpu_operand_stage: RTL and testbench
========================================

// Module: t07_fpu_operand_stage
// PURPOSE
// - Registered operand-issue stage between decode/regfile read and the multi-cycle FPU.
// - Per FPUOp, selects operand sources: integer regfile (int->float), FP regfile with A/B/C (FMA),
//   or FP regfile with A/B only. Unused slots are zeroed.
// - Forwards a same-cycle regfile writeback onto stale sources, then holds operands stable under
//   a valid/ready handshake until the FPU accepts them.
// PARAMETERS
// - XLEN      32  integer operand width
// - FLEN      32  FP operand width; FLEN >= XLEN is required
// - OPW       5   FPUOp width
// - NUM_FMA   4   number of FMA-class opcodes, 0..NUM_FMA-1 (use operand C)
// - I2F_OP0   21  first int->float opcode
// - I2F_OP1   22  second int->float opcode
// PORTS
// - clk          in   1     system clock
// - nRst         in   1     asynchronous, active-low reset
// - flush_i      in   1     synchronous kill of the held entry
// - in_valid_i   in   1     decode presents an FPU instruction
// - in_ready_o   out  1     stage can accept this cycle
// - FPUOp_i      in   OPW   operation code
// - rs1_i        in   5     source register index A
// - rs2_i        in   5     source register index B
// - rs3_i        in   5     source register index C
// - rd_i         in   5     destination register index, passed through
// - regValA_i    in   XLEN  integer regfile value A
// - regValB_i    in   XLEN  integer regfile value B
// - fregValA_i   in   FLEN  FP regfile value A
// - fregValB_i   in   FLEN  FP regfile value B
// - fregValC_i   in   FLEN  FP regfile value C
// - wb_en_i      in   1     writeback occurring this cycle
// - wb_fp_i      in   1     1 = FP regfile target, 0 = integer regfile target
// - wb_rd_i      in   5     writeback register index
// - wb_data_i    in   FLEN  writeback data (low XLEN bits used for integer targets)
// - out_valid_o  out  1     operands valid to the FPU
// - out_ready_i  in   1     FPU accepts this cycle
// - FPUOp_o      out  OPW   registered operation code
// - rd_o         out  5     registered destination index
// - FPUValA_o    out  FLEN  registered operand A
// - FPUValB_o    out  FLEN  registered operand B
// - FPUValC_o    out  FLEN  registered operand C
// BEHAVIOUR
// - Reset: all outputs are 0; state = EMPTY.
// - FSM states:
//   - EMPTY: accept -> FULL.
//   - FULL: out_ready_i & ~in_valid_i -> EMPTY; out_ready_i & in_valid_i -> FULL (new entry loaded
//     the same cycle); otherwise hold.
// - in_ready_o = EMPTY | out_ready_i (combinational pass-through of ready). Accept = in_valid_i & in_ready_o.
// - out_valid_o = FULL. Latency: 1 cycle from accept to out_valid_o. Throughput: 1 per cycle.
// - Operand class, decided on FPUOp_i at accept:
//   - I2F (op == I2F_OP0 or op == I2F_OP1): A/B = int values zero-extended to FLEN; C = 0.
//   - FMA (op < NUM_FMA): A/B/C = FP values.
//   - Otherwise: A/B = FP values; C = 0.
// - Forwarding:
//   - A source is replaced by wb_data_i when wb_en_i and the regfile kind matches the class
//     (I2F sources use ~wb_fp_i; FP sources use wb_fp_i) and the index matches.
//   - Integer x0 is never forwarded. FP f0 is forwarded.
//   - Forwarding applies only at accept.
// - While FULL and not accepted by the FPU, op/rd/operands are held bit-stable.
// - flush_i has priority over everything: next state = EMPTY, out_valid_o = 0 next cycle, input
//   ignored that cycle. Held data registers may keep stale values.
// - Reset asserted mid-transaction: the entry is dropped immediately and outputs go to 0.
// STRUCTURE
// - Package t07_fpu_pkg holds: the FPUOp enum (incl. I2F/FMA codes), the operand-class typedef
//   {I2F, FMA, FP2}, and a function returning the class for an op.
// - One natural sub-module: t07_fpu_fwd_sel, a combinational source select plus forward for a
//   single operand slot, instantiated three times.
// - The FSM and data registers live in the top module.
// TESTING
// - I2F: op=21, regValA=0xDEADBEEF, regValB=5 -> 1 cycle later out_valid=1, A=0xDEADBEEF, B=5, C=0.
// - FMA with stall: op=0, fregA/B/C=0x3F800000/0x40000000/0x40400000, out_ready=0 for 3 cycles
//   -> values held stable, in_ready=0; out_ready=1 -> entry retires.
// - Forwarding: op=4, rs1=7, wb_en=1, wb_fp=1, wb_rd=7, wb_data=0x12345678 -> A=0x12345678.
//   Same with wb_fp=0 -> no forward. Integer target with rd=0 -> no forward.
// - Back-to-back: in_valid held high with out_ready=1 for 4 ops -> 4 consecutive out_valid
//   cycles, in order.
// - Flush: FULL, flush_i=1 with in_valid=1 -> next cycle out_valid=0, new op not captured.
// - Reset: async nRst low mid-FULL -> out_valid and all operands 0 without a clock edge.

Source files
------------

// File: rtl/t07_fpu_pkg.sv
// t07_fpu_pkg: shared opcode, operand-class and stage-state types for the FPU operand stage
package t07_fpu_pkg;

   localparam int XLEN_DEF    = 32;
   localparam int FLEN_DEF    = 32;
   localparam int OPW_DEF     = 5;
   localparam int NUM_FMA_DEF = 4;
   localparam int I2F_OP0_DEF = 21;
   localparam int I2F_OP1_DEF = 22;

   typedef enum logic [OPW_DEF-1:0] {
      OP_FMADD     = 5'd0,
      OP_FMSUB     = 5'd1,
      OP_FNMSUB    = 5'd2,
      OP_FNMADD    = 5'd3,
      OP_FADD      = 5'd4,
      OP_FSUB      = 5'd5,
      OP_FMUL      = 5'd6,
      OP_FDIV      = 5'd7,
      OP_FSQRT     = 5'd8,
      OP_FSGNJ     = 5'd9,
      OP_FMINMAX   = 5'd10,
      OP_FCMP      = 5'd11,
      OP_FCVT_W_S  = 5'd12,
      OP_FCLASS    = 5'd13,
      OP_FCVT_S_W  = 5'd21,
      OP_FCVT_S_WU = 5'd22
   } fpu_op_e;

   typedef enum logic [1:0] {
      CLS_I2F,
      CLS_FMA,
      CLS_FP2
   } op_cls_e;

   typedef enum logic {
      EMPTY,
      FULL
   } stage_state_e;

   // int->float opcodes win over the FMA range so a reordered opcode map stays unambiguous
   function automatic op_cls_e op_class(input int op, input int num_fma, input int i2f0, input int i2f1);
      return (op == i2f0 || op == i2f1) ? CLS_I2F : (op < num_fma) ? CLS_FMA : CLS_FP2;
   endfunction

endpackage

// File: rtl/t07_fpu_fwd_sel.sv
// t07_fpu_fwd_sel: source select plus writeback forward for one operand slot
module t07_fpu_fwd_sel
   import t07_fpu_pkg::*;
#(
   parameter int XLEN = XLEN_DEF,
   parameter int FLEN = FLEN_DEF
) (
   input  logic            used,
   input  logic            is_int,
   input  logic [4:0]      rs,
   input  logic [XLEN-1:0] int_val,
   input  logic [FLEN-1:0] fp_val,
   input  logic            wb_en,
   input  logic            wb_fp,
   input  logic [4:0]      wb_rd,
   input  logic [FLEN-1:0] wb_data,
   output logic [FLEN-1:0] val
);

   logic hit;

   // forward only from the matching regfile kind; integer x0 is hardwired and never forwarded
   always_comb begin
      hit = wb_en && (wb_rd == rs) && (is_int ? (!wb_fp && rs != 5'd0) : wb_fp);
      val = !used ? '0 :
            is_int ? (hit ? FLEN'(wb_data[XLEN-1:0]) : FLEN'(int_val)) :
            (hit ? wb_data : fp_val);
   end

endmodule

// File: rtl/t07_fpu_operand_stage.sv
// t07_fpu_operand_stage: registered operand-issue stage with forwarding and valid/ready hold
module t07_fpu_operand_stage
   import t07_fpu_pkg::*;
#(
   parameter int XLEN    = XLEN_DEF,
   parameter int FLEN    = FLEN_DEF,
   parameter int OPW     = OPW_DEF,
   parameter int NUM_FMA = NUM_FMA_DEF,
   parameter int I2F_OP0 = I2F_OP0_DEF,
   parameter int I2F_OP1 = I2F_OP1_DEF
) (
   input  logic            clk,
   input  logic            nRst,
   input  logic            flush_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [OPW-1:0]  FPUOp_i,
   input  logic [4:0]      rs1_i,
   input  logic [4:0]      rs2_i,
   input  logic [4:0]      rs3_i,
   input  logic [4:0]      rd_i,
   input  logic [XLEN-1:0] regValA_i,
   input  logic [XLEN-1:0] regValB_i,
   input  logic [FLEN-1:0] fregValA_i,
   input  logic [FLEN-1:0] fregValB_i,
   input  logic [FLEN-1:0] fregValC_i,
   input  logic            wb_en_i,
   input  logic            wb_fp_i,
   input  logic [4:0]      wb_rd_i,
   input  logic [FLEN-1:0] wb_data_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [OPW-1:0]  FPUOp_o,
   output logic [4:0]      rd_o,
   output logic [FLEN-1:0] FPUValA_o,
   output logic [FLEN-1:0] FPUValB_o,
   output logic [FLEN-1:0] FPUValC_o
);

   stage_state_e    state, state_d;
   op_cls_e         cls;
   logic            load;
   logic [FLEN-1:0] val_a, val_b, val_c;

   assign in_ready_o  = (state == EMPTY) || out_ready_i;
   assign load        = in_valid_i && in_ready_o && !flush_i;
   assign out_valid_o = (state == FULL);
   assign cls         = op_class(int'(FPUOp_i), NUM_FMA, I2F_OP0, I2F_OP1);

   t07_fpu_fwd_sel #(.XLEN(XLEN), .FLEN(FLEN)) u_sel_a (
      .used(1'b1), .is_int(cls == CLS_I2F), .rs(rs1_i), .int_val(regValA_i), .fp_val(fregValA_i),
      .wb_en(wb_en_i), .wb_fp(wb_fp_i), .wb_rd(wb_rd_i), .wb_data(wb_data_i), .val(val_a)
   );

   t07_fpu_fwd_sel #(.XLEN(XLEN), .FLEN(FLEN)) u_sel_b (
      .used(1'b1), .is_int(cls == CLS_I2F), .rs(rs2_i), .int_val(regValB_i), .fp_val(fregValB_i),
      .wb_en(wb_en_i), .wb_fp(wb_fp_i), .wb_rd(wb_rd_i), .wb_data(wb_data_i), .val(val_b)
   );

   t07_fpu_fwd_sel #(.XLEN(XLEN), .FLEN(FLEN)) u_sel_c (
      .used(cls == CLS_FMA), .is_int(1'b0), .rs(rs3_i), .int_val('0), .fp_val(fregValC_i),
      .wb_en(wb_en_i), .wb_fp(wb_fp_i), .wb_rd(wb_rd_i), .wb_data(wb_data_i), .val(val_c)
   );

   // flush dominates; a retiring entry is replaced in the same cycle when a new one is loaded
   always_comb begin
      state_d = state;
      if (flush_i) state_d = EMPTY;
      else if (load) state_d = FULL;
      else if (out_ready_i) state_d = EMPTY;
   end

   // stage occupancy register
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) state <= EMPTY;
      else state <= state_d;
   end

   // operand registers only change on load, which keeps them bit-stable while stalled
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         FPUOp_o   <= '0;
         rd_o      <= '0;
         FPUValA_o <= '0;
         FPUValB_o <= '0;
         FPUValC_o <= '0;
      end else if (load) begin
         FPUOp_o   <= FPUOp_i;
         rd_o      <= rd_i;
         FPUValA_o <= val_a;
         FPUValB_o <= val_b;
         FPUValC_o <= val_c;
      end
   end

endmodule

// File: tb/tb_t07_fpu_operand_stage.sv
// tb_t07_fpu_operand_stage: scoreboard bench with directed cases and randomized traffic
module tb_t07_fpu_operand_stage;

   typedef struct {
      logic [4:0]  op;
      logic [4:0]  rd;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
   } ent_t;

   logic        clk, nRst, flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
   logic [4:0]  FPUOp_i, rs1_i, rs2_i, rs3_i, rd_i, wb_rd_i, FPUOp_o, rd_o;
   logic [31:0] regValA_i, regValB_i, fregValA_i, fregValB_i, fregValC_i, wb_data_i;
   logic [31:0] FPUValA_o, FPUValB_o, FPUValC_o;
   logic        wb_en_i, wb_fp_i;

   int   checks = 0;
   int   failures = 0;
   ent_t q[$];
   bit   model_full = 0;

   t07_fpu_operand_stage dut (
      .clk(clk), .nRst(nRst), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .FPUOp_i(FPUOp_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rs3_i(rs3_i), .rd_i(rd_i),
      .regValA_i(regValA_i), .regValB_i(regValB_i),
      .fregValA_i(fregValA_i), .fregValB_i(fregValB_i), .fregValC_i(fregValC_i),
      .wb_en_i(wb_en_i), .wb_fp_i(wb_fp_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .FPUOp_o(FPUOp_o), .rd_o(rd_o),
      .FPUValA_o(FPUValA_o), .FPUValB_o(FPUValB_o), .FPUValC_o(FPUValC_o)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", n, got, exp);
      end
   endtask

   function automatic logic [31:0] src(input bit int_kind, input logic [4:0] rs, input logic [31:0] v);
      if (wb_en_i && wb_rd_i == rs && (int_kind ? (!wb_fp_i && rs != 0) : wb_fp_i)) return wb_data_i;
      return v;
   endfunction

   function automatic ent_t expect_ent();
      ent_t e;
      bit   i2f, fma;
      i2f  = (FPUOp_i == 21) || (FPUOp_i == 22);
      fma  = !i2f && (FPUOp_i < 4);
      e.op = FPUOp_i;
      e.rd = rd_i;
      e.a  = i2f ? src(1, rs1_i, regValA_i) : src(0, rs1_i, fregValA_i);
      e.b  = i2f ? src(1, rs2_i, regValB_i) : src(0, rs2_i, fregValB_i);
      e.c  = fma ? src(0, rs3_i, fregValC_i) : 32'd0;
      return e;
   endfunction

   task automatic tick();
      bit   load;
      ent_t e;
      load = in_valid_i && (!model_full || out_ready_i) && !flush_i;
      e = expect_ent();
      @(posedge clk);
      #1;
      if (load) q.push_back(e);
      model_full = flush_i ? 1'b0 : load ? 1'b1 : (model_full && out_ready_i) ? 1'b0 : model_full;
      @(negedge clk);
   endtask

   task automatic idle();
      flush_i = 0; in_valid_i = 0; out_ready_i = 1; FPUOp_i = 0;
      rs1_i = 1; rs2_i = 2; rs3_i = 3; rd_i = 0;
      regValA_i = 0; regValB_i = 0; fregValA_i = 0; fregValB_i = 0; fregValC_i = 0;
      wb_en_i = 0; wb_fp_i = 0; wb_rd_i = 0; wb_data_i = 0;
   endtask

   task automatic randomize_data();
      rs1_i = 5'($urandom_range(0, 3)); rs2_i = 5'($urandom_range(0, 3));
      rs3_i = 5'($urandom_range(0, 3)); rd_i = 5'($urandom);
      regValA_i = $urandom; regValB_i = $urandom;
      fregValA_i = $urandom; fregValB_i = $urandom; fregValC_i = $urandom;
      wb_en_i = 1'($urandom); wb_fp_i = 1'($urandom);
      wb_rd_i = 5'($urandom_range(0, 3)); wb_data_i = $urandom;
   endtask

   // monitor: compares the presented entry with the scoreboard head, retires it on handshake or flush
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (nRst) begin
            chk("in_ready", 32'(in_ready_o), 32'(q.size() == 0 || out_ready_i));
            chk("out_valid", 32'(out_valid_o), 32'(q.size() != 0));
            if (q.size() != 0 && out_valid_o) begin
               chk("op", 32'(FPUOp_o), 32'(q[0].op));
               chk("rd", 32'(rd_o), 32'(q[0].rd));
               chk("val_a", FPUValA_o, q[0].a);
               chk("val_b", FPUValB_o, q[0].b);
               chk("val_c", FPUValC_o, q[0].c);
               if (out_ready_i || flush_i) void'(q.pop_front());
            end
         end
      end
   end

   initial begin
      nRst = 0;
      idle();
      #2;
      chk("rst_valid", 32'(out_valid_o), 0);
      chk("rst_op", 32'(FPUOp_o), 0);
      chk("rst_rd", 32'(rd_o), 0);
      chk("rst_a", FPUValA_o, 0);
      chk("rst_b", FPUValB_o, 0);
      chk("rst_c", FPUValC_o, 0);
      @(negedge clk);
      nRst = 1;
      @(negedge clk);

      // int->float
      FPUOp_i = 21; rs1_i = 1; rs2_i = 2; regValA_i = 32'hDEADBEEF; regValB_i = 5;
      fregValA_i = 32'h11111111; fregValC_i = 32'h22222222; in_valid_i = 1;
      tick();
      in_valid_i = 0;
      chk("i2f_valid", 32'(out_valid_o), 1);
      chk("i2f_a", FPUValA_o, 32'hDEADBEEF);
      chk("i2f_b", FPUValB_o, 32'd5);
      chk("i2f_c", FPUValC_o, 32'd0);
      tick();

      // FMA held under stall while decode keeps offering a different op
      idle();
      FPUOp_i = 0; fregValA_i = 32'h3F800000; fregValB_i = 32'h40000000; fregValC_i = 32'h40400000;
      in_valid_i = 1; out_ready_i = 0;
      tick();
      FPUOp_i = 4; fregValA_i = 32'hFFFFFFFF;
      for (int i = 0; i < 3; i++) begin
         chk("stall_ready", 32'(in_ready_o), 0);
         tick();
         chk("stall_a", FPUValA_o, 32'h3F800000);
         chk("stall_c", FPUValC_o, 32'h40400000);
      end
      in_valid_i = 0; out_ready_i = 1;
      tick();
      chk("fma_retired", 32'(out_valid_o), 0);

      // forwarding cases, loaded back to back
      idle();
      FPUOp_i = 4; rs1_i = 7; fregValA_i = 32'h11111111; in_valid_i = 1;
      wb_en_i = 1; wb_fp_i = 1; wb_rd_i = 7; wb_data_i = 32'h12345678;
      tick();
      chk("fwd_fp", FPUValA_o, 32'h12345678);
      wb_fp_i = 0;
      tick();
      chk("fwd_kind", FPUValA_o, 32'h11111111);
      FPUOp_i = 22; rs1_i = 0; regValA_i = 32'h0000AAAA; wb_rd_i = 0;
      tick();
      chk("fwd_x0", FPUValA_o, 32'h0000AAAA);
      FPUOp_i = 1; rs1_i = 0; wb_fp_i = 1;
      tick();
      chk("fwd_f0", FPUValA_o, 32'h12345678);

      // back-to-back
      idle();
      in_valid_i = 1;
      for (int i = 0; i < 4; i++) begin
         FPUOp_i = 5'(4 + i);
         randomize_data();
         tick();
         chk("b2b_valid", 32'(out_valid_o), 1);
      end
      in_valid_i = 0;
      tick();

      // flush while full with a new op offered
      idle();
      FPUOp_i = 6; fregValA_i = 32'h55555555; in_valid_i = 1; out_ready_i = 0;
      tick();
      flush_i = 1; FPUOp_i = 7; fregValA_i = 32'h66666666;
      tick();
      idle();
      chk("flush_valid", 32'(out_valid_o), 0);
      tick();

      // asynchronous reset in the middle of a held entry
      FPUOp_i = 2; fregValA_i = 32'h77777777; fregValB_i = 32'h88888888; fregValC_i = 32'h99999999;
      in_valid_i = 1; out_ready_i = 0;
      tick();
      in_valid_i = 0;
      #2;
      nRst = 0;
      q.delete();
      model_full = 0;
      #1;
      chk("arst_valid", 32'(out_valid_o), 0);
      chk("arst_a", FPUValA_o, 0);
      chk("arst_b", FPUValB_o, 0);
      chk("arst_c", FPUValC_o, 0);
      @(negedge clk);
      #2;
      nRst = 1;
      @(negedge clk);

      // randomized traffic
      idle();
      for (int i = 0; i < 400; i++) begin
         in_valid_i  = ($urandom % 4) != 0;
         out_ready_i = ($urandom % 3) != 0;
         flush_i     = ($urandom % 20) == 0;
         case ($urandom % 4)
            0: FPUOp_i = 5'($urandom_range(0, 3));
            1: FPUOp_i = 5'($urandom_range(21, 22));
            2: FPUOp_i = 5'($urandom_range(4, 13));
            default: FPUOp_i = 5'($urandom);
         endcase
         randomize_data();
         tick();
      end

      idle();
      tick();
      tick();
      chk("drain", 32'(q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
